// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_pkg
// Brief    : Shared widths, reset address and state encoding for the IFU.
// Revision : 1.0
// ============================================================================
package ifu_fetch_pkg;

    localparam int          PC_W     = 64;
    localparam int          INST_W   = 32;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DRAIN = 3'd4
    } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_if
// Brief    : Instruction-memory, decoder and redirect signals of the IFU.
// Revision : 1.0
// ============================================================================
interface ifu_fetch_if #(
    parameter int PC_W = ifu_fetch_pkg::PC_W
);
    import ifu_fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              imem_resp_err;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic              out_fault;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    // master: the fetch unit itself
    modport master (
        output imem_req_valid, imem_req_addr,
        output out_valid, out_inst, out_pc, out_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_inst, out_pc, out_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output out_ready, redirect_valid, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Single-outstanding instruction fetch unit with redirect and drain.
// Revision : 1.0
// ============================================================================
module ifu_fetch #(
    parameter int              PC_W     = ifu_fetch_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(ifu_fetch_pkg::RESET_PC)
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);
    import ifu_fetch_pkg::*;

    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);

    ifu_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;
    logic              out_fault_q, out_fault_d;

    logic w_misaligned;
    logic w_req_fire;

    assign w_misaligned = |pc_q[1:0];
    assign w_req_fire   = (state_q == ST_REQ) && !w_misaligned && bus.imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_fault_q <= out_fault_d;
        end
    end

    // A redirect always wins; only the landing state depends on whether a
    // request is still in flight at the memory.
    always_comb begin
        state_d     = state_q;
        pc_d        = bus.redirect_valid ? bus.redirect_pc : pc_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_fault_d = out_fault_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (bus.redirect_valid) begin
                    state_d = (w_req_fire && !bus.imem_resp_valid) ? ST_DRAIN : ST_REQ;
                end else if (w_misaligned) begin
                    state_d     = ST_OUT;
                    out_inst_d  = '0;
                    out_pc_d    = pc_q;
                    out_fault_d = 1'b1;
                end else if (w_req_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) begin
                    state_d = bus.imem_resp_valid ? ST_REQ : ST_DRAIN;
                end else if (bus.imem_resp_valid) begin
                    state_d     = ST_OUT;
                    out_inst_d  = bus.imem_resp_data;
                    out_pc_d    = pc_q;
                    out_fault_d = bus.imem_resp_err;
                end
            end
            ST_OUT: begin
                if (bus.redirect_valid) begin
                    state_d = ST_REQ;
                end else if (bus.out_ready) begin
                    state_d = ST_REQ;
                    pc_d    = pc_q + c_PC_STEP;
                end
            end
            ST_DRAIN: begin
                if (bus.imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = (state_q == ST_REQ) && !w_misaligned;
        bus.imem_req_addr  = pc_q;
        bus.out_valid      = (state_q == ST_OUT);
        bus.out_inst       = out_inst_q;
        bus.out_pc         = out_pc_q;
        bus.out_fault      = out_fault_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Scoreboard bench for ifu_fetch with a latency-varying memory model.
// Revision : 1.0
// ============================================================================
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [63:0] c_RST_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_if #(.PC_W(64)) bus ();
    ifu_fetch #(.PC_W(64), .RESET_PC(c_RST_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          total = 0;
    int          bad   = 0;
    int          hs_count = 0;
    exp_t        exp_q[$];
    logic [63:0] stream_pc;
    int          mem_lat = 1;
    int          stale_req = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] - 32'h8000_0000) * 32'h9E37_79B1 ^ 32'h0000_0013;
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        return ((32'(a[11:2]) % 32'd7) == 32'd3);
    endfunction

    // Architectural view: an entry is the word at pc, or a fault with zero data.
    function automatic exp_t expect_of(input logic [63:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.inst  = 32'h0;
            e.fault = 1'b1;
        end else begin
            e.inst  = mem_word(pc);
            e.fault = mem_err(pc);
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(expect_of(stream_pc));
            stream_pc += 64'd4;
        end
    endtask

    task automatic restart_stream(input logic [63:0] pc);
        exp_q.delete();
        stream_pc = pc;
        topup();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        restart_stream(pc);
    endtask

    task automatic wait_out(input int limit, output bit ok);
        int k = 0;
        while (k < limit && !bus.out_valid) begin
            step();
            k++;
        end
        ok = bus.out_valid;
    endtask

    task automatic wait_req(input int limit, output bit ok);
        int k = 0;
        while (k < limit && !bus.imem_req_valid) begin
            step();
            k++;
        end
        ok = bus.imem_req_valid;
    endtask

    // Monitor and memory responder, both on the falling edge.
    bit          pend = 1'b0;
    bit          just_acc;
    logic [63:0] pend_addr;
    int          pend_delay;
    int          stale_done = 0;
    exp_t        mon_e;
    bit          prev_req_hold = 1'b0;
    bit          prev_out_hold = 1'b0;
    logic [63:0] prev_addr, prev_pc;
    logic [31:0] prev_inst;
    logic        prev_fault;

    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            just_acc = 1'b0;
            if (rst) begin
                pend          = 1'b0;
                prev_req_hold = 1'b0;
                prev_out_hold = 1'b0;
            end else begin
                if (prev_req_hold) begin
                    check("req_hold_valid", bus.imem_req_valid, 64'd1);
                    check("req_hold_addr", bus.imem_req_addr, prev_addr);
                end
                if (prev_out_hold) begin
                    check("out_hold_valid", bus.out_valid, 64'd1);
                    check("out_hold_pc", bus.out_pc, prev_pc);
                    check("out_hold_inst", bus.out_inst, prev_inst);
                    check("out_hold_fault", bus.out_fault, prev_fault);
                end
                if (bus.imem_req_valid) begin
                    check("req_aligned", bus.imem_req_addr[1:0], 64'd0);
                    if (bus.imem_req_ready) begin
                        check("one_outstanding", pend, 64'd0);
                        pend       = 1'b1;
                        just_acc   = 1'b1;
                        pend_addr  = bus.imem_req_addr;
                        pend_delay = (mem_lat == 0) ? int'($urandom_range(0, 2)) : mem_lat - 1;
                    end
                end
                if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got pc %0h want none", bus.out_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("sb_pc", bus.out_pc, mon_e.pc);
                        check("sb_inst", bus.out_inst, mon_e.inst);
                        check("sb_fault", bus.out_fault, mon_e.fault);
                        hs_count++;
                    end
                end
                prev_req_hold = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
                prev_out_hold = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
                prev_addr  = bus.imem_req_addr;
                prev_pc    = bus.out_pc;
                prev_inst  = bus.out_inst;
                prev_fault = bus.out_fault;
            end
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom();
            bus.imem_resp_err   = 1'($urandom_range(0, 1));
            if (stale_req != stale_done) begin
                stale_done          = stale_req;
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = 32'hDEAD_BEEF;
                bus.imem_resp_err   = 1'b0;
            end else if (pend && !just_acc) begin
                if (pend_delay == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(pend_addr);
                    bus.imem_resp_err   = mem_err(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_delay--;
                end
            end
        end
    end

    initial begin
        bit          ok;
        int          first;
        int          k;
        int          seen;
        int          changed;
        logic [63:0] pcs[2];
        int          n_pc;
        logic [63:0] rec_pc;
        logic [31:0] rec_inst;
        logic [63:0] tgt;

        rst                = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        restart_stream(c_RST_PC);
        repeat (3) step();
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_req_valid", bus.imem_req_valid, 64'd0);
        check("rst_out_fault", bus.out_fault, 64'd0);
        check("rst_out_inst", bus.out_inst, 64'd0);
        check("rst_out_pc", bus.out_pc, 64'd0);

        // Minimum latency and back-to-back sequential fetch
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        mem_lat            = 1;
        rst                = 1'b0;
        first = -1;
        n_pc  = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (bus.out_valid) begin
                if (first < 0) first = i;
                if (n_pc < 2) pcs[n_pc] = bus.out_pc;
                if (n_pc == 0) rec_inst = bus.out_inst;
                n_pc++;
            end
        end
        check("first_out_cycle", 64'(first), 64'd3);
        check("first_out_pc", pcs[0], 64'h8000_0000);
        check("first_out_inst", rec_inst, 64'h13);
        check("second_out_pc", pcs[1], 64'h8000_0004);

        // Decoder stall: outputs held, no new memory request
        bus.out_ready = 1'b0;
        wait_out(20, ok);
        check("stall_reach_out", ok, 64'd1);
        rec_pc  = bus.out_pc;
        seen    = 0;
        changed = 0;
        repeat (5) begin
            step();
            if (bus.imem_req_valid) seen++;
            if (!bus.out_valid || bus.out_pc != rec_pc) changed++;
        end
        check("stall_no_req", 64'(seen), 64'd0);
        check("stall_stable", 64'(changed), 64'd0);
        bus.out_ready = 1'b1;

        // Redirect while waiting on a slow response: drain, then refetch target
        mem_lat = 3;
        wait_req(20, ok);
        check("drain_reach_req", ok, 64'd1);
        step();
        redirect_to(64'h8000_0100);
        step();
        bus.redirect_valid = 1'b0;
        k    = 0;
        seen = 0;
        while (k < 10 && !bus.imem_req_valid) begin
            if (bus.out_valid) seen++;
            step();
            k++;
        end
        mem_lat = 1;
        check("drain_cycles", 64'(k), 64'd2);
        check("drain_no_out", 64'(seen), 64'd0);
        check("drain_next_addr", bus.imem_req_addr, 64'h8000_0100);

        // Misaligned target: fault entry, no memory traffic
        step();
        bus.out_ready = 1'b0;
        redirect_to(64'h8000_0102);
        step();
        bus.redirect_valid = 1'b0;
        k    = 0;
        seen = 0;
        while (k < 10 && !bus.out_valid) begin
            if (bus.imem_req_valid) seen++;
            step();
            k++;
        end
        check("mis_no_req", 64'(seen), 64'd0);
        check("mis_valid", bus.out_valid, 64'd1);
        check("mis_fault", bus.out_fault, 64'd1);
        check("mis_pc", bus.out_pc, 64'h8000_0102);
        check("mis_inst", bus.out_inst, 64'd0);
        bus.out_ready = 1'b1;
        step();

        // Access fault reported by memory
        redirect_to(64'h8000_0204);
        step();
        bus.redirect_valid = 1'b0;
        wait_out(20, ok);
        check("err_valid", ok, 64'd1);
        check("err_fault", bus.out_fault, 64'd1);
        check("err_pc", bus.out_pc, 64'h8000_0204);
        check("err_inst", bus.out_inst, mem_word(64'h8000_0204));

        // Reset while a request is outstanding; stale response must be ignored
        mem_lat = 3;
        wait_req(20, ok);
        check("rstw_reach_req", ok, 64'd1);
        step();
        rst = 1'b1;
        restart_stream(c_RST_PC);
        step();
        check("rstw_out_valid", bus.out_valid, 64'd0);
        check("rstw_req_valid", bus.imem_req_valid, 64'd0);
        check("rstw_out_pc", bus.out_pc, 64'd0);
        check("rstw_out_inst", bus.out_inst, 64'd0);
        check("rstw_out_fault", bus.out_fault, 64'd0);
        rst = 1'b0;
        stale_req++;
        mem_lat = 1;
        wait_req(20, ok);
        check("rstw_req_addr", bus.imem_req_addr, c_RST_PC);
        wait_out(20, ok);
        check("rstw_out_pc2", bus.out_pc, c_RST_PC);
        check("rstw_out_inst2", bus.out_inst, 64'h13);

        // Randomized traffic
        mem_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            bus.redirect_valid = 1'b0;
            bus.imem_req_ready = ($urandom_range(0, 99) < 60);
            bus.out_ready      = ($urandom_range(0, 99) < 70);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 999) < 3) begin
                rst = 1'b1;
                restart_stream(c_RST_PC);
            end else if ($urandom_range(0, 99) < 5) begin
                tgt = c_RST_PC + (64'($urandom_range(0, 255)) << 2);
                if ($urandom_range(0, 99) < 20) tgt[1:0] = 2'($urandom_range(1, 3));
                redirect_to(tgt);
            end
        end
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (10) step();
        check("random_handshakes", (hs_count > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter PC_W, default 64, SHALL be the PC/address width; instruction width SHALL be fixed at 32.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  SHALL indicate a fetch request is presented.
REQ-006 imem_req_ready  input  1  SHALL indicate the instruction memory accepts the request this cycle.
REQ-007 imem_req_addr  output  PC_W  SHALL carry the fetch address.
REQ-008 imem_resp_valid  input  1  SHALL mark a returned instruction word.
REQ-009 imem_resp_data  input  32  SHALL carry the returned instruction word.
REQ-010 imem_resp_err  input  1  SHALL flag an access fault on the response.
REQ-011 out_valid  output  1  SHALL mark an instruction offered to the decoder.
REQ-012 out_ready  input  1  SHALL indicate the decoder consumes the offered instruction.
REQ-013 out_inst  output  32  SHALL carry the fetched instruction.
REQ-014 out_pc  output  PC_W  SHALL carry that instruction's PC.
REQ-015 out_fault  output  1  SHALL flag a misaligned or access-faulting fetch, qualified by out_valid.
REQ-016 redirect_valid  input  1  SHALL request a PC change from execute (branch/jump).
REQ-017 redirect_pc  input  PC_W  SHALL carry the redirect target.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, OUT, DRAIN.
REQ-019 IDLE SHALL go to REQ after one cycle.
REQ-020 REQ SHALL assert imem_req_valid with imem_req_addr = pc; handshake goes to WAIT.
REQ-021 imem_req_addr SHALL stay stable while imem_req_valid is high and imem_req_ready is low.
REQ-022 In WAIT, imem_resp_valid SHALL register data/err into out_inst/out_fault, set out_pc = pc, and go to OUT; out_valid SHALL rise the cycle after the response.
REQ-023 At most one request SHALL be outstanding.
REQ-024 In OUT, out_valid SHALL stay high with stable outputs until out_ready; on handshake pc <= pc + 4 (mod 2^PC_W), state goes to REQ.
REQ-025 Minimum latency SHALL be: request accepted cycle N, response N+1, out_valid N+2; throughput is one instruction per 3 cycles at best.
REQ-026 redirect_valid SHALL take priority over every other event in the same cycle: pc <= redirect_pc and out_valid deasserts next cycle.
REQ-027 A redirect in REQ (before acceptance) or OUT SHALL go to REQ.
REQ-028 A redirect in REQ on the request-acceptance cycle, or in WAIT, SHALL go to DRAIN unless imem_resp_valid is high that cycle, which goes to REQ.
REQ-029 DRAIN SHALL discard the next response without producing output, then go to REQ; a further redirect in DRAIN SHALL update pc only.
REQ-030 A pc with pc[1:0] != 0 in REQ SHALL issue no memory request and go directly to OUT with out_fault = 1, out_inst = 0.
REQ-031 A faulting entry SHALL be held until out_ready; its handshake advances pc by 4 like a normal entry.

Reset
REQ-032 rst SHALL force state = IDLE, pc = RESET_PC, and out_valid, imem_req_valid, out_fault low, out_inst = 0, out_pc = 0.
REQ-033 rst mid-transaction SHALL abandon any outstanding request; a stale response arriving after reset SHALL be ignored because it lands in IDLE/REQ.

Structure
REQ-034 Shared package SHALL hold PC_W, INST_W = 32, RESET_PC, and the IFU state enum.
REQ-035 ifu_fetch SHALL be one flat module; no sub-module is warranted.

Verification
REQ-036 Reset, then memory ready with 1-cycle latency returning 0x00000013 -> out_valid at cycle 3, out_pc 0x8000_0000, then 0x8000_0004.
REQ-037 out_ready held low 5 cycles -> out_inst/out_pc stable, no new imem request issued.
REQ-038 redirect_valid to 0x8000_0100 during WAIT, response arrives 2 cycles later -> response discarded, next request addr 0x8000_0100.
REQ-039 Redirect to 0x8000_0102 -> no memory request, out_valid with out_fault = 1, out_pc 0x8000_0102.
REQ-040 imem_resp_err = 1 -> out_fault = 1; rst asserted while in WAIT -> outputs cleared, next request addr RESET_PC.
